// File: rtl/conv_3x3_sched.sv
// rtl/conv_3x3_sched.sv - weight/pixel read sequencer for one 3x3 convolution layer
module conv_3x3_sched #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 16,
  parameter int IMAGE_HEIGHT    = 16,
  parameter int CHANNEL_NUM_IN  = 512,
  parameter int CHANNEL_NUM_OUT = 512,
  parameter int KERNEL_SIZE     = 9,
  parameter int PXL_ADDR_WIDTH  = 17,
  parameter int WGT_ADDR_WIDTH  = 22
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      hold,
  output logic                      wgt_rd_en,
  output logic [WGT_ADDR_WIDTH-1:0] wgt_rd_addr,
  output logic                      pxl_rd_en,
  output logic [PXL_ADDR_WIDTH-1:0] pxl_rd_addr,
  output logic                      wgt_valid,
  output logic                      pxl_valid,
  output logic                      first_ch,
  output logic                      last_ch,
  output logic [9:0]                ch_out_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int K_W  = (KERNEL_SIZE > 1)    ? $clog2(KERNEL_SIZE)    : 1;
  localparam int P_W  = (IMAGE_SIZE > 1)     ? $clog2(IMAGE_SIZE)     : 1;
  localparam int CI_W = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

  // Elaboration-time sanity checks on the parameter set.
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("conv_3x3_sched: DATA_WIDTH must be positive");
  end
  if (CHANNEL_NUM_OUT > 1024) begin : g_bad_cout
    $error("conv_3x3_sched: CHANNEL_NUM_OUT does not fit ch_out_idx");
  end
  if ((CHANNEL_NUM_IN * IMAGE_SIZE - 1) >= (1 << PXL_ADDR_WIDTH)) begin : g_bad_pxl_w
    $error("conv_3x3_sched: PXL_ADDR_WIDTH too small");
  end
  if ((CHANNEL_NUM_OUT * CHANNEL_NUM_IN * KERNEL_SIZE - 1) >= (1 << WGT_ADDR_WIDTH)) begin : g_bad_wgt_w
    $error("conv_3x3_sched: WGT_ADDR_WIDTH too small");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    NEXT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [P_W-1:0]            p_q, p_d;
  logic [CI_W-1:0]           ci_q, ci_d;
  logic [9:0]                co_q, co_d;
  logic [WGT_ADDR_WIDTH-1:0] wgt_rd_addr_q, wgt_rd_addr_d;
  logic [PXL_ADDR_WIDTH-1:0] pxl_rd_addr_q, pxl_rd_addr_d;
  logic                      wgt_valid_q, wgt_valid_d;
  logic                      pxl_valid_q, pxl_valid_d;
  logic                      first_ch_q, first_ch_d;
  logic                      last_ch_q, last_ch_d;
  logic [9:0]                ch_out_idx_q, ch_out_idx_d;

  // State, counters, addresses and the read-aligned strobe/flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      p_q           <= '0;
      ci_q          <= '0;
      co_q          <= '0;
      wgt_rd_addr_q <= '0;
      pxl_rd_addr_q <= '0;
      wgt_valid_q   <= 1'b0;
      pxl_valid_q   <= 1'b0;
      first_ch_q    <= 1'b0;
      last_ch_q     <= 1'b0;
      ch_out_idx_q  <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      p_q           <= p_d;
      ci_q          <= ci_d;
      co_q          <= co_d;
      wgt_rd_addr_q <= wgt_rd_addr_d;
      pxl_rd_addr_q <= pxl_rd_addr_d;
      wgt_valid_q   <= wgt_valid_d;
      pxl_valid_q   <= pxl_valid_d;
      first_ch_q    <= first_ch_d;
      last_ch_q     <= last_ch_d;
      ch_out_idx_q  <= ch_out_idx_d;
    end
  end

  // Next-state, counter stepping and read enables; hold only stalls the two read states.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    p_d           = p_q;
    ci_d          = ci_q;
    co_d          = co_q;
    wgt_rd_addr_d = wgt_rd_addr_q;
    pxl_rd_addr_d = pxl_rd_addr_q;
    wgt_rd_en     = 1'b0;
    pxl_rd_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD_W;
          k_d           = '0;
          p_d           = '0;
          ci_d          = '0;
          co_d          = '0;
          wgt_rd_addr_d = '0;
          pxl_rd_addr_d = '0;
        end
      end
      LOAD_W: begin
        if (!hold) begin
          wgt_rd_en     = 1'b1;
          wgt_rd_addr_d = wgt_rd_addr_q + WGT_ADDR_WIDTH'(1);
          if (k_q == K_W'(KERNEL_SIZE - 1)) begin
            k_d     = '0;
            state_d = STREAM;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      STREAM: begin
        if (!hold) begin
          pxl_rd_en     = 1'b1;
          pxl_rd_addr_d = pxl_rd_addr_q + PXL_ADDR_WIDTH'(1);
          if (p_q == P_W'(IMAGE_SIZE - 1)) begin
            p_d     = '0;
            state_d = NEXT;
          end else begin
            p_d = p_q + P_W'(1);
          end
        end
      end
      NEXT: begin
        if (ci_q < CI_W'(CHANNEL_NUM_IN - 1)) begin
          ci_d    = ci_q + CI_W'(1);
          state_d = LOAD_W;
        end else if (co_q < 10'(CHANNEL_NUM_OUT - 1)) begin
          co_d          = co_q + 10'd1;
          ci_d          = '0;
          pxl_rd_addr_d = '0;
          state_d       = LOAD_W;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-cycle delayed strobes and channel flags, aligned with the returned memory data.
  always_comb begin
    wgt_valid_d  = wgt_rd_en;
    pxl_valid_d  = pxl_rd_en;
    first_ch_d   = pxl_rd_en && (ci_q == '0);
    last_ch_d    = pxl_rd_en && (ci_q == CI_W'(CHANNEL_NUM_IN - 1));
    ch_out_idx_d = co_q;
  end

  assign wgt_rd_addr = wgt_rd_addr_q;
  assign pxl_rd_addr = pxl_rd_addr_q;
  assign wgt_valid   = wgt_valid_q;
  assign pxl_valid   = pxl_valid_q;
  assign first_ch    = first_ch_q;
  assign last_ch     = last_ch_q;
  assign ch_out_idx  = ch_out_idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_conv_3x3_sched.sv
// tb/tb_conv_3x3_sched.sv - directed self-checking bench for conv_3x3_sched (4x4 image, 2 in, 2 out)
module tb_conv_3x3_sched;

  localparam int PAIR_CYC  = 26;   // 9 weights + 16 pixels + 1 NEXT
  localparam int LAYER_CYC = 105;  // 4 pairs * 26 + DONE

  logic        clk;
  logic        reset;
  logic        start;
  logic        hold;
  logic        wgt_rd_en;
  logic [21:0] wgt_rd_addr;
  logic        pxl_rd_en;
  logic [16:0] pxl_rd_addr;
  logic        wgt_valid;
  logic        pxl_valid;
  logic        first_ch;
  logic        last_ch;
  logic [9:0]  ch_out_idx;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  conv_3x3_sched #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .KERNEL_SIZE(9),
    .PXL_ADDR_WIDTH(17), .WGT_ADDR_WIDTH(22)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
    .pxl_rd_en(pxl_rd_en), .pxl_rd_addr(pxl_rd_addr),
    .wgt_valid(wgt_valid), .pxl_valid(pxl_valid),
    .first_ch(first_ch), .last_ch(last_ch), .ch_out_idx(ch_out_idx),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wgt_rd_en"},   32'(wgt_rd_en),   0);
    chk({tag, ".wgt_rd_addr"}, 32'(wgt_rd_addr), 0);
    chk({tag, ".pxl_rd_en"},   32'(pxl_rd_en),   0);
    chk({tag, ".pxl_rd_addr"}, 32'(pxl_rd_addr), 0);
    chk({tag, ".wgt_valid"},   32'(wgt_valid),   0);
    chk({tag, ".pxl_valid"},   32'(pxl_valid),   0);
    chk({tag, ".first_ch"},    32'(first_ch),    0);
    chk({tag, ".last_ch"},     32'(last_ch),     0);
    chk({tag, ".ch_out_idx"},  32'(ch_out_idx),  0);
    chk({tag, ".busy"},        32'(busy),        0);
    chk({tag, ".done"},        32'(done),        0);
  endtask

  // Runs one layer from IDLE. The expected timeline is the fixed per-pair pattern:
  // offset t<9 weight read j*9+t, 9<=t<25 pixel read (ci*16 + t-9), t=25 NEXT, then DONE.
  // A hold cycle in a read phase freezes the timeline position.
  task automatic run_layer(input string tag, input int hold_pair, input int hold_t,
                           input int hold_len, input int start_at, input bit start_in_done);
    int e, cyc, hcnt, j, t, ci, co;
    bit exp_w, exp_p, prev_w, prev_p;
    int prev_ci, prev_co;
    e = 0; cyc = 0; hcnt = 0;
    prev_w = 0; prev_p = 0; prev_ci = 0; prev_co = 0;
    @(negedge clk);
    start = 1'b1; hold = 1'b0;
    #1;
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    while (e < LAYER_CYC && cyc < 400) begin
      @(negedge clk);
      j  = e / PAIR_CYC;
      t  = e % PAIR_CYC;
      ci = j % 2;
      co = j / 2;
      hold  = (e < LAYER_CYC - 1) && (j == hold_pair) && (t == hold_t) && (hcnt < hold_len);
      start = (cyc == start_at) || (start_in_done && e == LAYER_CYC - 1);
      #1;
      exp_w = 0; exp_p = 0;
      chk({tag, ".busy"}, 32'(busy), 1);
      if (e == LAYER_CYC - 1) begin
        chk({tag, ".done"}, 32'(done), 1);
      end else begin
        chk({tag, ".done"}, 32'(done), 0);
        if (t < 9) begin
          exp_w = !hold;
          chk({tag, ".wgt_rd_addr"}, 32'(wgt_rd_addr), 32'(j * 9 + t));
        end else if (t < 25) begin
          exp_p = !hold;
          chk({tag, ".pxl_rd_addr"}, 32'(pxl_rd_addr), 32'(ci * 16 + t - 9));
        end
      end
      chk({tag, ".wgt_rd_en"}, 32'(wgt_rd_en), 32'(exp_w));
      chk({tag, ".pxl_rd_en"}, 32'(pxl_rd_en), 32'(exp_p));
      chk({tag, ".wgt_valid"}, 32'(wgt_valid), 32'(prev_w));
      chk({tag, ".pxl_valid"}, 32'(pxl_valid), 32'(prev_p));
      chk({tag, ".first_ch"},  32'(first_ch),  32'(prev_p && prev_ci == 0));
      chk({tag, ".last_ch"},   32'(last_ch),   32'(prev_p && prev_ci == 1));
      if (prev_p) chk({tag, ".ch_out_idx"}, 32'(ch_out_idx), 32'(prev_co));
      prev_w = exp_w; prev_p = exp_p; prev_ci = ci; prev_co = co;
      if (hold) hcnt++;
      else e++;
      cyc++;
    end
    chk({tag, ".layer_cycles"}, 32'(cyc), 32'(LAYER_CYC + hold_len));
    @(negedge clk);
    start = 1'b0; hold = 1'b0;
    #1;
    chk({tag, ".after_busy"}, 32'(busy), 0);
    chk({tag, ".after_done"}, 32'(done), 0);
    chk({tag, ".after_wgt_rd_en"}, 32'(wgt_rd_en), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");

    @(negedge clk);
    reset = 1'b1;

    // Plain layer; a start in the DONE cycle must be ignored.
    run_layer("full", -1, 0, 0, -1, 1'b1);

    // Back-to-back: second layer from address 0, identical timeline.
    run_layer("b2b", -1, 0, 0, -1, 1'b0);

    // Hold for 3 cycles at k=4 of the first pair.
    run_layer("hold_k", 0, 4, 3, -1, 1'b0);

    // Hold for 3 cycles at p=7 of the second pair, plus a start pulse during STREAM.
    run_layer("hold_p", 1, 16, 3, 15, 1'b0);

    // Reset asserted mid-STREAM aborts everything.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("mid.pxl_rd_en_before_reset", 32'(pxl_rd_en), 1);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("mid_reset_hold");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_reset.busy", 32'(busy), 0);
    run_layer("after_reset", -1, 0, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_3x3_sched.md
# conv_3x3_sched

Sequencing controller for one 3x3 convolution layer instance. On `start` it walks every (output channel, input channel) pair: it fetches the 9 kernel weights from the weight memory, then streams one full input-channel feature map from the pixel memory. Its valid strobes drive the `valid_weight_in` and `valid_in` inputs of the 3x3 conv top. It also flags the first and last input channel so the downstream accumulator knows when to clear and when to emit.

## Interface
- DATA_WIDTH, 32: data word width; used only for documentation consistency.
- IMAGE_WIDTH, 16: feature map width.
- IMAGE_HEIGHT, 16: feature map height; IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT.
- CHANNEL_NUM_IN, 512: input channels per output channel.
- CHANNEL_NUM_OUT, 512: output channels.
- KERNEL_SIZE, 9: weights per kernel.
- PXL_ADDR_WIDTH, 17: pixel memory address width; must hold CHANNEL_NUM_IN*IMAGE_SIZE-1.
- WGT_ADDR_WIDTH, 22: weight memory address width; must hold CHANNEL_NUM_OUT*CHANNEL_NUM_IN*KERNEL_SIZE-1.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  layer start request; sampled only in IDLE.
- hold  in  1  stall request; freezes all reads and counters.
- wgt_rd_en  out  1  weight memory read enable.
- wgt_rd_addr  out  WGT_ADDR_WIDTH  weight memory read address.
- pxl_rd_en  out  1  pixel memory read enable.
- pxl_rd_addr  out  PXL_ADDR_WIDTH  pixel memory read address.
- wgt_valid  out  1  `wgt_rd_en` delayed 1 cycle; drives `valid_weight_in`.
- pxl_valid  out  1  `pxl_rd_en` delayed 1 cycle; drives `valid_in`.
- first_ch  out  1  qualifies `pxl_valid`: the current input channel is 0.
- last_ch  out  1  qualifies `pxl_valid`: the current input channel is CHANNEL_NUM_IN-1.
- ch_out_idx  out  10  current output channel index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at layer completion.

## Operation
- The state machine has five states: IDLE, LOAD_W, STREAM, NEXT, DONE.
- IDLE:
  - Transition: start=1 -> LOAD_W.
  - Action on start: clear k, p, ci, co, wgt_rd_addr and pxl_rd_addr.
- LOAD_W:
  - Per cycle with hold=0: wgt_rd_en=1, then wgt_rd_addr++ and k++.
  - Transition: after the read with k=8 -> STREAM, with k cleared.
- STREAM:
  - Per cycle with hold=0: pxl_rd_en=1, then pxl_rd_addr++ and p++.
  - Transition: after the read with p=IMAGE_SIZE-1 -> NEXT, with p cleared.
- NEXT (one cycle, both rd_en low):
  - If ci<CHANNEL_NUM_IN-1: ci++ -> LOAD_W.
  - Else if co<CHANNEL_NUM_OUT-1: co++, ci=0, pxl_rd_addr=0 -> LOAD_W.
  - Else -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- wgt_rd_addr runs linearly over the whole layer and is never rewound (layout [co][ci][k]).
- pxl_rd_addr runs linearly over [ci][p] and rewinds to 0 at each new co.
- hold=1 in LOAD_W or STREAM: the read enable for that cycle is 0 and no counter, address or state changes. hold is ignored in IDLE, NEXT and DONE.
- start while busy is ignored.
- first_ch, last_ch and ch_out_idx are registered together with pxl_valid, so they align with the returned pixel data.

## Timing
- Reset value of every output is 0; reset also returns the state machine to IDLE.
- Asserting reset mid-layer aborts immediately: no done pulse, and all counters are cleared.
- Latency from start to the first wgt_rd_en is 1 cycle: start is sampled at edge N, and wgt_rd_en is high during cycle N+1.
- Memory read latency is 1 cycle, so valid strobes lag their read enables by exactly 1 cycle.
- Cycles per (co, ci) pair without hold: 9 + IMAGE_SIZE + 1.
- Total busy cycles without hold: CHANNEL_NUM_OUT*CHANNEL_NUM_IN*(10+IMAGE_SIZE) + 1 (the DONE cycle).
- wgt_rd_en and pxl_rd_en are never high in the same cycle.
- done rises in the cycle after the last NEXT.
- busy falls in the cycle after done.
- A start asserted in the same cycle as done is ignored; a new start is accepted once the block is back in IDLE.

## Test plan
- Reset values: with IMAGE 4x4, CIN=2, COUT=2, hold reset low mid-STREAM -> all outputs 0 and state IDLE; after release and start, wgt_rd_addr restarts at 0.
- Full run with the 4x4/2/2 configuration and hold=0:
  - wgt_rd_addr sequence is 0..35, in four bursts of 9.
  - pxl_rd_addr sequence per co is 0..31.
  - done arrives exactly 4*(10+16)+1 = 105 cycles after the first busy cycle.
- Channel flags: first_ch=1 only during the ci=0 pixel bursts; last_ch=1 only during the ci=1 pixel bursts; ch_out_idx steps 0 -> 1 at the second co.
- Hold stalls:
  - Assert hold for 3 cycles at k=4 -> wgt_rd_en is low for 3 cycles, the address holds at 4 and then resumes at 4.
  - Hold at p=7 behaves the same way; done arrives 3 cycles later per stall.
- Start while busy: pulse start during STREAM -> no effect on addresses or on done timing.
- Back-to-back layers: assert start in the done cycle (ignored), then again in IDLE -> the second layer runs identically from address 0.
